// File: rtl/stepper_ctrl_if.sv
// Move-command handshake between the CPU register glue and the stepper block.
// The master issues one command at a time, and the slave answers with cmd_ready.
interface stepper_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PER_W  = 20
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_ch;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [PER_W-1:0] cmd_period;

  modport master (output cmd_valid, cmd_ch, cmd_dir, cmd_steps, cmd_period,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_ch, cmd_dir, cmd_steps, cmd_period,
                  output cmd_ready);
endinterface

// File: rtl/stepper_ctrl.sv
// STEP/DIR pulse generator for NUM_CH stepper channels. Each channel is an independent
// IDLE/SETUP/HIGH/LOW sequencer, and a single command port loads one channel per cycle.
module stepper_ch #(
  parameter int CNT_W     = 16,
  parameter int PER_W     = 20,
  parameter int PULSE_W   = 100,
  parameter int DIR_SETUP = 10
) (
  input  logic             clock,
  input  logic             resetBtn,
  input  logic             accept,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [PER_W-1:0] eff_period,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  localparam logic [PER_W-1:0] HI_LAST = PER_W'(PULSE_W - 1);
  localparam logic [PER_W-1:0] SU_LAST = PER_W'(DIR_SETUP - 1);
  // LOW lasts period-PULSE_W cycles, so its down-counter starts one below that.
  localparam logic [PER_W-1:0] LO_OFS  = PER_W'(PULSE_W + 1);

  state_t           state, state_nx;
  logic [PER_W-1:0] phase, phase_nx;
  logic [PER_W-1:0] period, period_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic             dir_q, dir_nx;
  logic             done_q, done_nx;

  always_ff @(posedge clock or negedge resetBtn) begin
    if (!resetBtn) begin
      state  <= IDLE;
      phase  <= '0;
      period <= '0;
      rem    <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      phase  <= phase_nx;
      period <= period_nx;
      rem    <= rem_nx;
      dir_q  <= dir_nx;
      done_q <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    period_nx = period;
    rem_nx    = rem;
    dir_nx    = dir_q;
    done_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          period_nx = eff_period;
          dir_nx    = cmd_dir;
          rem_nx    = cmd_steps;
          if (cmd_steps == '0) begin
            done_nx = 1'b1;
          end else if (cmd_dir != dir_q) begin
            state_nx = SETUP;
            phase_nx = SU_LAST;
          end else begin
            // The first STEP edge goes out on the cycle after accept, so that step is already started.
            state_nx = HIGH;
            phase_nx = HI_LAST;
            rem_nx   = cmd_steps - CNT_W'(1);
          end
        end
      end
      SETUP: begin
        if (phase == '0) begin
          state_nx = HIGH;
          phase_nx = HI_LAST;
          rem_nx   = rem - CNT_W'(1);
        end else begin
          phase_nx = phase - PER_W'(1);
        end
      end
      HIGH: begin
        if (phase == '0) begin
          state_nx = LOW;
          phase_nx = period - LO_OFS;
        end else begin
          phase_nx = phase - PER_W'(1);
        end
      end
      LOW: begin
        if (phase != '0) begin
          phase_nx = phase - PER_W'(1);
        end else if (rem != '0) begin
          state_nx = HIGH;
          phase_nx = HI_LAST;
          rem_nx   = rem - CNT_W'(1);
        end else begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Abort takes priority over any in-flight phase. DIR is kept and no done pulse is given.
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      phase_nx = '0;
      rem_nx   = '0;
      done_nx  = 1'b0;
    end
  end

  assign step      = (state == HIGH);
  assign busy      = (state != IDLE);
  assign dir       = dir_q;
  assign done      = done_q;
  assign remaining = rem;
endmodule

module stepper_ctrl #(
  parameter  int NUM_CH    = 4,
  parameter  int CNT_W     = 16,
  parameter  int PER_W     = 20,
  parameter  int PULSE_W   = 100,
  parameter  int DIR_SETUP = 10,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clock,
  input  logic               resetBtn,
  stepper_ctrl_if.slave      cmd,
  input  logic [NUM_CH-1:0]  abort,
  output logic [NUM_CH-1:0]  step,
  output logic [NUM_CH-1:0]  dir,
  output logic [NUM_CH-1:0]  busy,
  output logic [NUM_CH-1:0]  done,
  input  logic [CH_W-1:0]    stat_ch,
  output logic [CNT_W-1:0]   stat_remaining
);
  localparam logic [PER_W-1:0] MIN_PER = PER_W'(PULSE_W + 1);

  logic                         ch_ok;
  logic                         stat_ok;
  logic [PER_W-1:0]             eff_period;
  logic [NUM_CH-1:0]            accept;
  logic [NUM_CH-1:0][CNT_W-1:0] rem_all;

  // Commands to a channel that does not exist are acknowledged and dropped.
  assign ch_ok         = (int'(cmd.cmd_ch) < NUM_CH);
  assign cmd.cmd_ready = ch_ok ? !busy[cmd.cmd_ch] : 1'b1;

  // Clamping the period guarantees that every LOW phase lasts at least one cycle.
  assign eff_period = (cmd.cmd_period < MIN_PER) ? MIN_PER : cmd.cmd_period;

  assign stat_ok        = (int'(stat_ch) < NUM_CH);
  assign stat_remaining = stat_ok ? rem_all[stat_ch] : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign accept[i] = cmd.cmd_valid & cmd.cmd_ready & ch_ok & (cmd.cmd_ch == CH_W'(i));

    stepper_ch #(
      .CNT_W    (CNT_W),
      .PER_W    (PER_W),
      .PULSE_W  (PULSE_W),
      .DIR_SETUP(DIR_SETUP)
    ) u_ch (
      .clock     (clock),
      .resetBtn  (resetBtn),
      .accept    (accept[i]),
      .cmd_dir   (cmd.cmd_dir),
      .cmd_steps (cmd.cmd_steps),
      .eff_period(eff_period),
      .abort     (abort[i]),
      .step      (step[i]),
      .dir       (dir[i]),
      .busy      (busy[i]),
      .done      (done[i]),
      .remaining (rem_all[i])
    );
  end
endmodule

// File: tb/tb_stepper_ctrl.sv
// Directed bench for stepper_ctrl. Each command pushes its expected STEP rise and done cycles
// into a scoreboard, and a negedge monitor pops and compares them as the outputs appear.
module tb_stepper_ctrl;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int PW_ = 20;
  localparam int PW  = 2;
  localparam int DS  = 3;

  logic            clock = 1'b0;
  logic            resetBtn = 1'b0;
  logic [NCH-1:0]  abort = '0;
  logic [NCH-1:0]  step, dir, busy, done;
  logic [1:0]      stat_ch = '0;
  logic [CW-1:0]   stat_remaining;

  stepper_ctrl_if #(.NUM_CH(NCH), .CNT_W(CW), .PER_W(PW_)) cif ();

  stepper_ctrl #(.NUM_CH(NCH), .CNT_W(CW), .PER_W(PW_), .PULSE_W(PW), .DIR_SETUP(DS)) dut (
    .clock(clock), .resetBtn(resetBtn), .cmd(cif.slave), .abort(abort),
    .step(step), .dir(dir), .busy(busy), .done(done),
    .stat_ch(stat_ch), .stat_remaining(stat_remaining)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int ch; int kind; int at;} ev_t;  // kind 0 = STEP rise, 1 = done
  ev_t sbq[$];

  int npass = 0, nfail = 0, ntot = 0;
  int cdir[NCH];
  int last_rise[NCH];
  bit killed[NCH];
  logic [NCH-1:0] step_prev = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic match(int ch, int kind);
    int idx = -1;
    for (int i = 0; i < sbq.size(); i++)
      if (idx < 0 && sbq[i].ch == ch && sbq[i].kind == kind) idx = i;
    chk(kind == 0 ? "rise_expected" : "done_expected", (idx >= 0), 1);
    if (idx >= 0) begin
      chk(kind == 0 ? "rise_cycle" : "done_cycle", cyc, sbq[idx].at);
      sbq.delete(idx);
    end
  endtask

  // Drop pending expectations (ch<0 = all channels) scheduled after cycle 'after'.
  task automatic flush(int ch, int after);
    for (int i = sbq.size() - 1; i >= 0; i--)
      if ((ch < 0 || sbq[i].ch == ch) && sbq[i].at > after) sbq.delete(i);
  endtask

  always @(negedge clock) begin
    if (resetBtn) begin
      for (int c = 0; c < NCH; c++) begin
        if (step[c] && !step_prev[c]) begin
          match(c, 0);
          last_rise[c] = cyc;
          killed[c] = 1'b0;
        end
        if (!step[c] && step_prev[c] && !killed[c]) chk("pulse_width", cyc - last_rise[c], PW);
        if (done[c]) begin
          match(c, 1);
          chk("busy_at_done", busy[c], 0);
        end
      end
      step_prev = step;
    end else begin
      step_prev = '0;
    end
  end

  // Drives one command, checks it is accepted, and schedules its expected events.
  // The task returns at the negedge right after the accepting edge, and a holds that cycle.
  task automatic send(int ch, bit d, int steps, int per, output int a);
    int eff, first;
    @(negedge clock);
    cif.cmd_valid  = 1'b1;
    cif.cmd_ch     = 2'(ch);
    cif.cmd_dir    = d;
    cif.cmd_steps  = 16'(steps);
    cif.cmd_period = 20'(per);
    #1 chk("cmd_ready", cif.cmd_ready, 1);
    a = cyc + 1;
    eff = (per < PW + 1) ? PW + 1 : per;
    first = a + ((int'(d) != cdir[ch]) ? DS : 0);
    cdir[ch] = int'(d);
    if (steps == 0) sbq.push_back('{ch, 1, a});
    else begin
      for (int k = 0; k < steps; k++) sbq.push_back('{ch, 0, first + k * eff});
      sbq.push_back('{ch, 1, first + steps * eff});
    end
    @(negedge clock);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 400 && sbq.size() > 0; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    chk(tag, sbq.size(), 0);
  endtask

  initial begin
    int a;
    cif.cmd_valid = 1'b0; cif.cmd_ch = '0; cif.cmd_dir = 1'b0;
    cif.cmd_steps = '0; cif.cmd_period = '0;
    for (int c = 0; c < NCH; c++) begin cdir[c] = 0; last_rise[c] = 0; killed[c] = 1'b0; end

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_remaining", stat_remaining, 0);
    chk("rst_ready", cif.cmd_ready, 1);
    #2 resetBtn = 1'b1;

    // Basic 3-step move on ch0
    send(0, 1'b0, 3, 10, a);
    #1;
    chk("t1_busy", busy[0], 1);
    chk("t1_remaining", stat_remaining, 2);
    drain("t1_drain");

    // Direction change on ch1 inserts the setup delay
    send(1, 1'b1, 1, 8, a);
    #1;
    chk("t2_dir", dir[1], 1);
    chk("t2_busy", busy[1], 1);
    chk("t2_step_setup", step[1], 0);
    drain("t2_drain");

    // A busy channel refuses commands, while another channel accepts them and runs concurrently
    send(0, 1'b0, 4, 12, a);
    cif.cmd_valid = 1'b1; cif.cmd_ch = 2'd0; cif.cmd_steps = 16'd1; cif.cmd_period = 20'd5;
    #1 chk("t3_ready_busy", cif.cmd_ready, 0);
    send(2, 1'b0, 2, 7, a);
    drain("t3_drain");

    // Abort during the second HIGH phase of a 5-step move
    send(0, 1'b0, 5, 10, a);
    stat_ch = 2'd0;
    while (cyc < a + 10) @(negedge clock);
    #1;
    chk("t4_step_high", step[0], 1);
    chk("t4_remaining", stat_remaining, 3);
    killed[0] = 1'b1;
    flush(0, cyc);
    abort = 4'b0001;
    @(negedge clock);
    abort = '0;
    #1;
    chk("t4_step_off", step[0], 0);
    chk("t4_busy_off", busy[0], 0);
    chk("t4_remaining0", stat_remaining, 0);
    repeat (30) @(negedge clock);
    chk("t4_still_idle", busy[0], 0);

    // A zero-step move only pulses done
    send(3, 1'b0, 0, 10, a);
    #1 chk("t5_busy", busy[3], 0);
    drain("t5_drain");

    // A too-short period is clamped to PULSE_W+1
    send(2, 1'b0, 3, 1, a);
    drain("t6_drain");

    // Reset mid-move
    send(0, 1'b1, 6, 10, a);
    while (cyc < a + 5) @(negedge clock);
    chk("t7_busy_before", busy[0], 1);
    #2 resetBtn = 1'b0;
    #1;
    chk("t7_step", step, 0);
    chk("t7_busy", busy, 0);
    chk("t7_dir", dir, 0);
    chk("t7_done", done, 0);
    flush(-1, -1);
    for (int c = 0; c < NCH; c++) cdir[c] = 0;
    repeat (3) @(negedge clock);
    #2 resetBtn = 1'b1;
    repeat (40) @(negedge clock);
    chk("t7_quiet_busy", busy, 0);
    chk("t7_quiet_remaining", stat_remaining, 0);
    drain("final_drain");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
